// File: rtl/shrimp_instruction_fetch.sv
// Two-byte instruction fetch: reads the low then high byte of the word at the PC and holds it for the decoder.
// Define SHRIMP_FETCH_ALIGN_CHECK_EN to stall and flag odd PCs instead of silently aligning them.
module shrimp_instruction_fetch (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instruction_address,
  input  logic        flush,
  output logic        pc_advance,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] instr_q;
  logic        misaligned_q;
  logic [15:0] base_addr;
  logic        odd_pc;
  logic        lo_stall;

`ifdef SHRIMP_FETCH_ALIGN_CHECK_EN
  assign base_addr  = instruction_address;
  assign odd_pc     = instruction_address[0];
  assign misaligned = misaligned_q;
`else
  assign base_addr  = instruction_address & 16'hFFFE;
  assign odd_pc     = 1'b0;
  assign misaligned = 1'b0;
`endif

  // Once an odd PC is seen the low fetch stays parked until a flush redirects it.
  assign lo_stall = odd_pc | misaligned_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      instr_q      <= 16'h0000;
      misaligned_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH_LO;
        end
        FETCH_LO: begin
          if (flush) begin
            state        <= FETCH_LO;
            misaligned_q <= 1'b0;
          end else if (lo_stall) begin
            misaligned_q <= 1'b1;
          end else if (mem_ack) begin
            instr_q[7:0] <= mem_rdata;
            state        <= FETCH_HI;
          end
        end
        FETCH_HI: begin
          if (flush) begin
            state <= FETCH_LO;
          end else if (mem_ack) begin
            instr_q[15:8] <= mem_rdata;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (flush || instr_ready) begin
            state <= FETCH_LO;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Request and handshake outputs follow the live PC so a freshly stepped counter is fetched at once.
  always_comb begin
    mem_req    = 1'b0;
    mem_addr   = 16'h0000;
    pc_advance = 1'b0;
    case (state)
      FETCH_LO: begin
        if (!lo_stall) begin
          mem_req  = 1'b1;
          mem_addr = base_addr;
        end
      end
      FETCH_HI: begin
        mem_req  = 1'b1;
        mem_addr = base_addr + 16'd1;
      end
      HOLD: begin
        pc_advance = instr_ready & ~flush;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign instr       = instr_q;
  assign instr_valid = (state == HOLD);

endmodule

// File: tb/tb_shrimp_instruction_fetch.sv
// Directed, table-driven bench for shrimp_instruction_fetch; honours SHRIMP_FETCH_ALIGN_CHECK_EN.
module tb_shrimp_instruction_fetch;

  logic        clock;
  logic        reset;
  logic [15:0] instruction_address;
  logic        flush;
  logic        pc_advance;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        misaligned;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic [15:0] pc;
    logic        fl;
    logic        ack;
    logic [7:0]  rd;
    logic        rdy;
    logic        e_adv;
    logic        e_req;
    logic [15:0] e_addr;
    logic [15:0] e_instr;
    logic        e_valid;
    logic        e_mis;
  } vec_t;

  vec_t vecs[22];

  shrimp_instruction_fetch dut (
    .clock               (clock),
    .reset               (reset),
    .instruction_address (instruction_address),
    .flush               (flush),
    .pc_advance          (pc_advance),
    .mem_req             (mem_req),
    .mem_addr            (mem_addr),
    .mem_ack             (mem_ack),
    .mem_rdata           (mem_rdata),
    .instr               (instr),
    .instr_valid         (instr_valid),
    .instr_ready         (instr_ready),
    .misaligned          (misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic rst, input logic [15:0] pc, input logic fl,
                              input logic ack, input logic [7:0] rd, input logic rdy,
                              input logic e_adv, input logic e_req, input logic [15:0] e_addr,
                              input logic [15:0] e_instr, input logic e_valid, input logic e_mis);
    vec_t v;
    v.rst = rst; v.pc = pc; v.fl = fl; v.ack = ack; v.rd = rd; v.rdy = rdy;
    v.e_adv = e_adv; v.e_req = e_req; v.e_addr = e_addr;
    v.e_instr = e_instr; v.e_valid = e_valid; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic check1(input string name, input string field, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s %s: got %h want %h", name, field, got, want);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, well before the next rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    reset               = v.rst;
    instruction_address = v.pc;
    flush               = v.fl;
    mem_ack             = v.ack;
    mem_rdata           = v.rd;
    instr_ready         = v.rdy;
    #1;
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    check1(name, "pc_advance",  {15'd0, pc_advance},  {15'd0, v.e_adv});
    check1(name, "mem_req",     {15'd0, mem_req},     {15'd0, v.e_req});
    check1(name, "mem_addr",    mem_addr,             v.e_addr);
    check1(name, "instr",       instr,                v.e_instr);
    check1(name, "instr_valid", {15'd0, instr_valid}, {15'd0, v.e_valid});
    check1(name, "misaligned",  {15'd0, misaligned},  {15'd0, v.e_mis});
  endtask

  task automatic runVec(input string name, input vec_t v);
    applyStimulus(v);
    checkOutput(name, v);
  endtask

  initial begin
    logic [15:0] instr_e;
    logic [15:0] instr_f;

    reset = 1'b0; instruction_address = 16'h0000; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = 8'h00; instr_ready = 1'b0;
    repeat (2) @(posedge clock);

    // Each row is one clock: inputs for the cycle and the outputs expected before its rising edge.
    vecs[0]  = mk(0, 16'h0000, 0, 0, 8'h00, 0,  0, 0, 16'h0000, 16'h0000, 0, 0);
    vecs[1]  = mk(1, 16'h0000, 0, 1, 8'h34, 0,  0, 0, 16'h0000, 16'h0000, 0, 0);
    vecs[2]  = mk(1, 16'h0000, 0, 1, 8'h34, 0,  0, 1, 16'h0000, 16'h0000, 0, 0);
    vecs[3]  = mk(1, 16'h0000, 0, 1, 8'h12, 0,  0, 1, 16'h0001, 16'h0034, 0, 0);
    vecs[4]  = mk(1, 16'h0000, 0, 0, 8'h00, 1,  1, 0, 16'h0000, 16'h1234, 1, 0);
    vecs[5]  = mk(1, 16'h0002, 0, 0, 8'h00, 0,  0, 1, 16'h0002, 16'h1234, 0, 0);
    vecs[6]  = mk(1, 16'h0002, 0, 1, 8'h78, 0,  0, 1, 16'h0002, 16'h1234, 0, 0);
    vecs[7]  = mk(1, 16'h0002, 0, 0, 8'h00, 0,  0, 1, 16'h0003, 16'h1278, 0, 0);
    vecs[8]  = mk(1, 16'h0002, 0, 0, 8'h00, 0,  0, 1, 16'h0003, 16'h1278, 0, 0);
    vecs[9]  = mk(1, 16'h0002, 0, 0, 8'h00, 0,  0, 1, 16'h0003, 16'h1278, 0, 0);
    vecs[10] = mk(1, 16'h0002, 0, 1, 8'h56, 0,  0, 1, 16'h0003, 16'h1278, 0, 0);
    vecs[11] = mk(1, 16'h0002, 0, 0, 8'h00, 0,  0, 0, 16'h0000, 16'h5678, 1, 0);
    vecs[12] = mk(1, 16'h0002, 1, 0, 8'h00, 1,  0, 0, 16'h0000, 16'h5678, 1, 0);
    vecs[13] = mk(1, 16'h0002, 0, 1, 8'h9A, 0,  0, 1, 16'h0002, 16'h5678, 0, 0);
    vecs[14] = mk(1, 16'h0002, 1, 1, 8'hBC, 0,  0, 1, 16'h0003, 16'h569A, 0, 0);
    vecs[15] = mk(1, 16'h0100, 0, 0, 8'h00, 0,  0, 1, 16'h0100, 16'h569A, 0, 0);
    vecs[16] = mk(1, 16'h0100, 0, 1, 8'h11, 0,  0, 1, 16'h0100, 16'h569A, 0, 0);
    vecs[17] = mk(1, 16'h0100, 0, 1, 8'h22, 0,  0, 1, 16'h0101, 16'h5611, 0, 0);
    vecs[18] = mk(1, 16'h0100, 0, 0, 8'h00, 0,  0, 0, 16'h0000, 16'h2211, 1, 0);
    vecs[19] = mk(0, 16'h0100, 0, 0, 8'h00, 0,  0, 0, 16'h0000, 16'h2211, 1, 0);
    vecs[20] = mk(0, 16'h0100, 0, 0, 8'h00, 0,  0, 0, 16'h0000, 16'h0000, 0, 0);
    vecs[21] = mk(1, 16'h0005, 0, 1, 8'hEF, 0,  0, 0, 16'h0000, 16'h0000, 0, 0);

    for (int i = 0; i < 22; i++) begin
      runVec($sformatf("row%0d", i), vecs[i]);
    end

`ifdef SHRIMP_FETCH_ALIGN_CHECK_EN
    runVec("odd_a",   mk(1, 16'h0005, 0, 1, 8'hEF, 0,  0, 0, 16'h0000, 16'h0000, 0, 0));
    runVec("odd_b",   mk(1, 16'h0005, 0, 1, 8'hEF, 0,  0, 0, 16'h0000, 16'h0000, 0, 1));
    runVec("odd_fl",  mk(1, 16'h0005, 1, 1, 8'hEF, 0,  0, 0, 16'h0000, 16'h0000, 0, 1));
    runVec("odd_clr", mk(1, 16'h0004, 0, 0, 8'h00, 0,  0, 1, 16'h0004, 16'h0000, 0, 0));
    instr_e = 16'h0000;
    instr_f = 16'h0001;
`else
    runVec("odd_lo",  mk(1, 16'h0005, 0, 1, 8'hEF, 0,  0, 1, 16'h0004, 16'h0000, 0, 0));
    runVec("odd_hi",  mk(1, 16'h0005, 0, 1, 8'hCD, 0,  0, 1, 16'h0005, 16'h00EF, 0, 0));
    runVec("odd_hold", mk(1, 16'h0005, 0, 0, 8'h00, 1, 1, 0, 16'h0000, 16'hCDEF, 1, 0));
    instr_e = 16'hCDEF;
    instr_f = 16'hCD01;
`endif

    // Reset arriving in the middle of a fetch must abort it and clear the word.
    runVec("mid_lo",   mk(1, 16'h0006, 0, 1, 8'h01, 0,  0, 1, 16'h0006, instr_e,  0, 0));
    runVec("mid_rst",  mk(0, 16'h0006, 0, 1, 8'h02, 0,  0, 1, 16'h0007, instr_f,  0, 0));
    runVec("post_rst", mk(0, 16'h0006, 0, 0, 8'h00, 0,  0, 0, 16'h0000, 16'h0000, 0, 0));
    runVec("release",  mk(1, 16'h0006, 0, 0, 8'h00, 0,  0, 0, 16'h0000, 16'h0000, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shrimp_instruction_fetch.md
SHRIMP_INSTRUCTION_FETCH -- requirements
Module: shrimp_instruction_fetch

Interface
REQ-001 SHALL have port: clock  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-003 SHALL have port: instruction_address  input  16  current PC from the instruction counter.
REQ-004 SHALL have port: flush  input  1  jump/redirect taken this cycle; discard fetch in progress.
REQ-005 SHALL have port: pc_advance  output  1  one-cycle pulse instructing counter to step to next instruction.
REQ-006 SHALL have port: mem_req  output  1  byte read request to instruction memory.
REQ-007 SHALL have port: mem_addr  output  16  byte address of request.
REQ-008 SHALL have port: mem_ack  input  1  memory accepted request; mem_rdata valid same cycle.
REQ-009 SHALL have port: mem_rdata  input  8  read byte.
REQ-010 SHALL have port: instr  output  16  fetched instruction word.
REQ-011 SHALL have port: instr_valid  output  1  instr holds a complete word.
REQ-012 SHALL have port: instr_ready  input  1  decoder consumes instr when high with instr_valid.
REQ-013 SHALL have port: misaligned  output  1  odd instruction_address detected (see Configuration).

Function
REQ-014 SHALL implement states IDLE, FETCH_LO, FETCH_HI, HOLD.
REQ-015 IDLE SHALL go to FETCH_LO on the first clock with reset deasserted.
REQ-016 FETCH_LO SHALL drive mem_req=1, mem_addr=instruction_address; on mem_ack, SHALL latch mem_rdata into instr[7:0] and go to FETCH_HI.
REQ-017 FETCH_HI SHALL drive mem_req=1, mem_addr=instruction_address+1 (16-bit, modulo 2^16); on mem_ack, SHALL latch mem_rdata into instr[15:8] and go to HOLD.
REQ-018 mem_req and mem_addr SHALL remain stable until mem_ack; mem_req SHALL be 0 in IDLE and HOLD.
REQ-019 HOLD SHALL drive instr_valid=1 with instr stable; instr_valid SHALL be 0 in all other states.
REQ-020 HOLD with instr_ready=1 and flush=0 SHALL assert pc_advance for exactly that cycle and go to FETCH_LO.
REQ-021 Minimum latency: FETCH_LO entry to instr_valid=1 SHALL be 2 cycles with mem_ack held high.
REQ-022 flush=1 in any non-IDLE state SHALL force next state FETCH_LO, discard any byte returned that cycle, keep pc_advance=0.
REQ-023 flush=1 and instr_ready=1 same cycle in HOLD: flush SHALL win; no pc_advance, instruction dropped.
REQ-024 pc_advance SHALL never assert outside HOLD.

Reset
REQ-025 reset=0 at a rising edge SHALL force state IDLE regardless of state, aborting any fetch.
REQ-026 During/after reset: pc_advance=0, mem_req=0, mem_addr=0x0000, instr=0x0000, instr_valid=0, misaligned=0.

Configuration
REQ-027 Macro SHRIMP_FETCH_ALIGN_CHECK_EN SHALL select alignment checking.
REQ-028 Defined: instruction_address[0]=1 in FETCH_LO SHALL set misaligned=1, issue no mem_req, hold in FETCH_LO until flush or reset; misaligned clears on flush or reset.
REQ-029 Not defined: instruction_address[0] SHALL be treated as 0 for mem_addr; misaligned SHALL be tied 0.

Verification
REQ-030 Reset release, PC=0x0000, mem_ack=1, rdata 0x34 then 0x12 -> mem_addr 0x0000,0x0001; instr=0x1234, instr_valid on 3rd cycle after IDLE.
REQ-031 HOLD, instr_ready=1 -> single-cycle pc_advance; next cycle FETCH_LO at new PC 0x0002.
REQ-032 mem_ack delayed 3 cycles in FETCH_HI -> mem_req/mem_addr 0x0003 stable all 3 cycles; instr_valid only after ack.
REQ-033 flush in FETCH_HI with mem_ack=1, PC redirected to 0x0100 -> byte discarded, next mem_addr 0x0100, no pc_advance.
REQ-034 HOLD with flush=1 and instr_ready=1 -> pc_advance=0, instr_valid=0 next cycle.
REQ-035 PC=0x0005, macro defined -> misaligned=1, mem_req=0; macro undefined -> mem_addr 0x0004,0x0005, misaligned=0.
